// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
package parking_pkg;

  localparam int DEF_CAPACITY    = 15;
  localparam int DEF_GATE_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_IN,
    OPEN_IN,
    GRANT_OUT,
    OPEN_OUT,
    FAULT
  } state_t;

  typedef enum logic {
    LANE_IN,
    LANE_OUT
  } lane_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable 8-bit down-counter; done while the count sits at zero.
module gate_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate arbiter for a parking lot with an external car counter.
//
// state     | meaning
// IDLE      | waiting for a feasible request
// GRANT_IN  | one-cycle entry grant, inc pulse, entry gate opens
// OPEN_IN   | entry gate held open until the timer expires
// GRANT_OUT | one-cycle exit grant, dec pulse, exit gate opens
// OPEN_OUT  | exit gate held open until the timer expires
// FAULT     | counter error seen; terminal until reset
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [3:0] count,
  input  logic       cnt_err,
  output logic       inc,
  output logic       dec,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_deny,
  output logic       exit_deny,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic       full,
  output logic       empty,
  output logic       fault
);

  localparam logic [3:0] CAP = 4'(CAPACITY);
  // The grant cycle is the first open cycle, so the open phase runs one short.
  localparam logic [7:0] OPEN_LOAD = 8'(GATE_CYCLES - 2);

  state_t state, next_state;
  lane_t  last_lane;
  logic   entry_ok, exit_ok;
  logic   timer_load, timer_en, timer_done;

  assign entry_ok = entry_req && (count < CAP);
  assign exit_ok  = exit_req && (count != 4'd0);

  assign timer_load = (state == GRANT_IN) || (state == GRANT_OUT);
  assign timer_en   = (state == OPEN_IN) || (state == OPEN_OUT);

  gate_timer u_gate_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (OPEN_LOAD),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_lane <= LANE_OUT;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GRANT_IN) begin
        last_lane <= LANE_IN;
      end else if (state == IDLE && next_state == GRANT_OUT) begin
        last_lane <= LANE_OUT;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (cnt_err) begin
      next_state = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (entry_ok && exit_ok) begin
            next_state = (last_lane == LANE_IN) ? GRANT_OUT : GRANT_IN;
          end else if (entry_ok) begin
            next_state = GRANT_IN;
          end else if (exit_ok) begin
            next_state = GRANT_OUT;
          end
        end
        GRANT_IN:  next_state = OPEN_IN;
        GRANT_OUT: next_state = OPEN_OUT;
        OPEN_IN,
        OPEN_OUT:  if (timer_done) next_state = IDLE;
        FAULT:     next_state = FAULT;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    inc        = 1'b0;
    dec        = 1'b0;
    entry_ack  = 1'b0;
    exit_ack   = 1'b0;
    entry_gate = 1'b0;
    exit_gate  = 1'b0;
    fault      = 1'b0;
    entry_deny = 1'b0;
    exit_deny  = 1'b0;
    case (state)
      IDLE: begin
        entry_deny = entry_req && (count >= CAP);
        exit_deny  = exit_req && (count == 4'd0);
      end
      GRANT_IN: begin
        inc        = 1'b1;
        entry_ack  = 1'b1;
        entry_gate = 1'b1;
      end
      OPEN_IN:  entry_gate = 1'b1;
      GRANT_OUT: begin
        dec       = 1'b1;
        exit_ack  = 1'b1;
        exit_gate = 1'b1;
      end
      OPEN_OUT: exit_gate = 1'b1;
      FAULT: begin
        fault      = 1'b1;
        entry_deny = entry_req;
        exit_deny  = exit_req;
      end
      default: ;
    endcase
  end

  assign full  = (count >= CAP);
  assign empty = (count == 4'd0);

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 15: maximum occupancy, range 1..15.
REQ-002 SHALL have parameter GATE_CYCLES, default 8: number of cycles a gate stays open after a grant, range 2..255.
REQ-003 SHALL have port clk, in, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, in, 1: reset, synchronous and active-low.
REQ-005 SHALL have port entry_req, in, 1: entry-lane car waiting; level, held until entry_ack or entry_deny.
REQ-006 SHALL have port exit_req, in, 1: exit-lane car waiting; level, held until exit_ack or exit_deny.
REQ-007 SHALL have port count, in, 4: current occupancy from the car counter.
REQ-008 SHALL have port cnt_err, in, 1: sticky error flag from the car counter.
REQ-009 SHALL have port inc, out, 1: one-cycle increment pulse to the car counter.
REQ-010 SHALL have port dec, out, 1: one-cycle decrement pulse to the car counter.
REQ-011 SHALL have ports entry_ack and exit_ack, out, 1 each: one-cycle grant pulses.
REQ-012 SHALL have ports entry_deny and exit_deny, out, 1 each: refusal indications (level).
REQ-013 SHALL have ports entry_gate and exit_gate, out, 1 each: gate-open drive.
REQ-014 SHALL have ports full, empty and fault, out, 1 each: lot status.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT_IN, OPEN_IN, GRANT_OUT, OPEN_OUT and FAULT.
REQ-016 Entry feasible = entry_req && count < CAPACITY; exit feasible = exit_req && count != 0.
REQ-017 In IDLE, with only entry feasible -> GRANT_IN next cycle; with only exit feasible -> GRANT_OUT next cycle.
REQ-018 In IDLE, with both feasible -> serve the lane not served last (round-robin); after reset, entry wins first.
REQ-019 GRANT_IN SHALL last exactly 1 cycle with inc=1, entry_ack=1 and entry_gate=1, then -> OPEN_IN; GRANT_OUT is the same with dec, exit_ack and exit_gate, then -> OPEN_OUT.
REQ-020 OPEN_IN/OPEN_OUT SHALL hold the matching gate=1 for GATE_CYCLES-1 cycles, then -> IDLE; the gate is high for GATE_CYCLES cycles in total.
REQ-021 Latency from a feasible request sampled in IDLE to ack SHALL be 1 cycle.
REQ-022 Requests arriving outside IDLE SHALL be held pending with no ack and no deny, and arbitrated on return to IDLE.
REQ-023 inc and dec SHALL never both be 1 in the same cycle, and at most one of each SHALL be issued per grant.
REQ-024 entry_deny = (state==IDLE) && entry_req && count >= CAPACITY; exit_deny = (state==IDLE) && exit_req && count == 0; both combinational.
REQ-025 full = (count >= CAPACITY) and empty = (count == 0), combinational from count.
REQ-026 cnt_err=1 in any state SHALL force FAULT on the next cycle, aborting any open gate (both gates 0).
REQ-027 FAULT SHALL be terminal until reset: fault=1, no inc, no dec, no ack, both deny outputs = the matching req.
REQ-028 The round-robin pointer SHALL update only on GRANT_IN/GRANT_OUT entry.

Reset
REQ-029 When rst=0 at a clock edge: state=IDLE, round-robin pointer=exit (so entry is preferred), gate timer=0.
REQ-030 Registered outputs inc, dec, acks, gates and fault SHALL be 0 in the cycle following the reset edge.
REQ-031 Reset asserted mid-grant or mid-open SHALL close the gate immediately with no further inc/dec.

Structure
REQ-032 SHALL take the state enum, the CAPACITY/GATE_CYCLES defaults and the lane enum (LANE_IN, LANE_OUT) from shared package parking_pkg.
REQ-033 SHALL use one sub-module, gate_timer: a loadable 8-bit down-counter with a done output.

Verification
REQ-034 count=3, entry_req=1 -> entry_ack and inc 1 cycle later for 1 cycle; entry_gate high for 8 cycles; count later 4.
REQ-035 count=15 (CAPACITY=15), entry_req=1 -> entry_deny=1 and full=1 while req is held; inc is never pulsed.
REQ-036 count=0, exit_req=1 -> exit_deny=1 and empty=1; dec=0.
REQ-037 count=5, entry_req and exit_req held continuously from reset -> grants in the order IN, OUT, IN, OUT, with each new grant only after the previous gate closes.
REQ-038 cnt_err=1 during OPEN_IN -> next cycle entry_gate=0 and fault=1; all later requests are denied until rst=0.
REQ-039 rst=0 during GRANT_OUT -> next cycle exit_gate=0, dec=0, state IDLE; a held entry_req is granted first after reset.
